// File: rtl/rf_wb_writer_pkg.sv
// Shared encodings, the MEM/WB record and the load-extension helper for the
// write-back stage.
package rf_wb_writer_pkg;

  localparam int MD_DEPTH = 2;

  localparam logic [1:0] WDSEL_ALU  = 2'b00;
  localparam logic [1:0] WDSEL_LOAD = 2'b01;
  localparam logic [1:0] WDSEL_PC4  = 2'b10;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

  // MEM/WB pipeline register contents; done marks an already-issued write.
  typedef struct packed {
    logic        valid;
    logic        regwr;
    logic [4:0]  rd;
    logic [1:0]  wdsel;
    logic [2:0]  ldop;
    logic [1:0]  addr_lo;
    logic [31:0] alu;
    logic [31:0] dmout;
    logic [31:0] pc4;
    logic        done;
  } memwb_t;

  // Pick the addressed byte/halfword out of an aligned word and extend it.
  function automatic logic [31:0] load_ext(input logic [2:0]  ldop,
                                           input logic [1:0]  addr_lo,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (ldop)
      LD_H:    r = {{16{h[15]}}, h};
      LD_HU:   r = {16'h0000, h};
      LD_B:    r = {{24{b[7]}}, b};
      LD_BU:   r = {24'h000000, b};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rf_wb_writer_if.sv
// Pipeline, mult/div and register-file port bundle of the write-back stage.
// Handshake: a mult/div result transfers on a posedge where md_valid and
// md_ready are both high; md_ready depends only on buffer occupancy, and the
// offerer must keep md_valid/md_rd/md_result stable until that edge.
interface rf_wb_writer_if;
  logic        mem_valid;
  logic        mem_regwr;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wdsel;
  logic [2:0]  mem_ldop;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_alu;
  logic [31:0] mem_dmout;
  logic [31:0] mem_pc4;
  logic        wb_stall;
  logic        wb_flush;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_result;
  logic        md_ready;
  logic [4:0]  q_rs;
  logic [4:0]  q_rt;
  logic        pend_rs;
  logic        pend_rt;
  logic        stall_req;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic        RFWr;

  modport slave (
    input  mem_valid, mem_regwr, mem_rd, mem_wdsel, mem_ldop, mem_addr_lo,
           mem_alu, mem_dmout, mem_pc4, wb_stall, wb_flush,
           md_valid, md_rd, md_result, q_rs, q_rt,
    output md_ready, pend_rs, pend_rt, stall_req, A3, WD, RFWr
  );

  modport master (
    output mem_valid, mem_regwr, mem_rd, mem_wdsel, mem_ldop, mem_addr_lo,
           mem_alu, mem_dmout, mem_pc4, wb_stall, wb_flush,
           md_valid, md_rd, md_result, q_rs, q_rt,
    input  md_ready, pend_rs, pend_rt, stall_req, A3, WD, RFWr
  );
endinterface

// File: rtl/rf_wb_writer_fifo.sv
// Two-entry {rd,data} buffer for late mult/div results. Entry rd fields and
// their occupancy are exposed so the stage can flag pending destinations.
module wb_md_fifo (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [4:0]      push_rd,
  input  logic [31:0]     push_data,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output logic [4:0]      head_rd,
  output logic [31:0]     head_data,
  output logic [1:0][4:0] ent_rd,
  output logic [1:0]      ent_vld
);
  logic [1:0][4:0]  rd_mem;
  logic [1:0][31:0] data_mem;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign ent_rd    = rd_mem;

  // An entry is live when the buffer is full or it is the sole head entry.
  always_comb begin
    ent_vld = '0;
    for (int i = 0; i < 2; i++) begin
      ent_vld[i] = full || (!empty && (rd_ptr == 1'(i)));
    end
  end

  // Storage, wrapping 1-bit pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_mem   <= '0;
      data_mem <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_push) begin
        rd_mem[wr_ptr]   <= push_rd;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rf_wb_writer.sv
// Write-back stage: MEM/WB register, load extension, write-data select and
// arbitration of the single RF write port between the pipeline and the
// buffered mult/div results.
module rf_wb_writer
  import rf_wb_writer_pkg::*;
(
  input logic          clk,
  input logic          rst,
  rf_wb_writer_if.slave bus
);
  memwb_t           r;
  logic             pipe_pending;
  logic             pipe_wr;
  logic [31:0]      pipe_wd;
  logic             stall_req_w;
  logic             fifo_push;
  logic             fifo_pop;
  logic             full;
  logic             empty;
  logic [4:0]       head_rd;
  logic [31:0]      head_data;
  logic [1:0][4:0]  ent_rd;
  logic [1:0]       ent_vld;

  // rd==0 never counts as pending, so such an entry behaves as already done.
  assign pipe_pending = r.valid && r.regwr && (r.rd != 5'd0) && !r.done;
  assign fifo_push    = bus.md_valid && !full;
  assign bus.md_ready = !full;
  assign bus.stall_req = stall_req_w;

  wb_md_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_rd   (bus.md_rd),
    .push_data (bus.md_result),
    .pop       (fifo_pop),
    .full      (full),
    .empty     (empty),
    .head_rd   (head_rd),
    .head_data (head_data),
    .ent_rd    (ent_rd),
    .ent_vld   (ent_vld)
  );

  // Write-data source for the pipeline entry.
  always_comb begin
    case (r.wdsel)
      WDSEL_LOAD: pipe_wd = load_ext(r.ldop, r.addr_lo, r.dmout);
      WDSEL_PC4:  pipe_wd = r.pc4;
      default:    pipe_wd = r.alu;
    endcase
  end

  // Port arbitration: full buffer drains first, then pipeline, then buffer.
  always_comb begin
    bus.RFWr    = 1'b0;
    bus.A3      = 5'd0;
    bus.WD      = 32'd0;
    fifo_pop    = 1'b0;
    pipe_wr     = 1'b0;
    stall_req_w = 1'b0;
    if (full) begin
      fifo_pop    = 1'b1;
      stall_req_w = pipe_pending;
      if (head_rd != 5'd0) begin
        bus.RFWr = 1'b1;
        bus.A3   = head_rd;
        bus.WD   = head_data;
      end
    end else if (pipe_pending) begin
      pipe_wr  = 1'b1;
      bus.RFWr = 1'b1;
      bus.A3   = r.rd;
      bus.WD   = pipe_wd;
    end else if (!empty) begin
      fifo_pop = 1'b1;
      if (head_rd != 5'd0) begin
        bus.RFWr = 1'b1;
        bus.A3   = head_rd;
        bus.WD   = head_data;
      end
    end
  end

  // Pending-destination check against buffered and currently offered results.
  always_comb begin
    bus.pend_rs = (bus.q_rs != 5'd0) &&
                  ((ent_vld[0] && ent_rd[0] == bus.q_rs) ||
                   (ent_vld[1] && ent_rd[1] == bus.q_rs) ||
                   (bus.md_valid && bus.md_rd == bus.q_rs));
    bus.pend_rt = (bus.q_rt != 5'd0) &&
                  ((ent_vld[0] && ent_rd[0] == bus.q_rt) ||
                   (ent_vld[1] && ent_rd[1] == bus.q_rt) ||
                   (bus.md_valid && bus.md_rd == bus.q_rt));
  end

  // MEM/WB register: flush beats hold, hold keeps fields but records an issued write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= '0;
    end else if (bus.wb_flush) begin
      r.valid <= 1'b0;
    end else if (bus.wb_stall || stall_req_w) begin
      r.done <= r.done | pipe_wr;
    end else begin
      r <= '{valid:   bus.mem_valid,
             regwr:   bus.mem_regwr,
             rd:      bus.mem_rd,
             wdsel:   bus.mem_wdsel,
             ldop:    bus.mem_ldop,
             addr_lo: bus.mem_addr_lo,
             alu:     bus.mem_alu,
             dmout:   bus.mem_dmout,
             pc4:     bus.mem_pc4,
             done:    1'b0};
    end
  end
endmodule

// File: tb/tb_rf_wb_writer.sv
// Bench for the write-back stage: table of single-cycle writes, then
// hand-written sequences for buffering, ordering, rd==0, stall/flush, reset.
module tb_rf_wb_writer;
  import rf_wb_writer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rf_wb_writer_if bus();

  rf_wb_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [36:0] exp_q[$];
  logic [36:0] sb_e;

  typedef struct {
    logic [4:0]  rd;
    logic [1:0]  wdsel;
    logic [2:0]  ldop;
    logic [1:0]  addr_lo;
    logic [31:0] alu;
    logic [31:0] dmout;
    logic [31:0] pc4;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_valid   = 1'b0;
    bus.mem_regwr   = 1'b0;
    bus.mem_rd      = 5'd0;
    bus.mem_wdsel   = WDSEL_ALU;
    bus.mem_ldop    = LD_W;
    bus.mem_addr_lo = 2'd0;
    bus.mem_alu     = 32'd0;
    bus.mem_dmout   = 32'd0;
    bus.mem_pc4     = 32'd0;
    bus.wb_stall    = 1'b0;
    bus.wb_flush    = 1'b0;
    bus.md_valid    = 1'b0;
    bus.md_rd       = 5'd0;
    bus.md_result   = 32'd0;
    bus.q_rs        = 5'd0;
    bus.q_rt        = 5'd0;
  endtask

  task automatic drive_mem(input logic [4:0] rd, input logic [1:0] wdsel,
                           input logic [2:0] ldop, input logic [1:0] addr_lo,
                           input logic [31:0] alu, input logic [31:0] dmout,
                           input logic [31:0] pc4);
    bus.mem_valid   = 1'b1;
    bus.mem_regwr   = 1'b1;
    bus.mem_rd      = rd;
    bus.mem_wdsel   = wdsel;
    bus.mem_ldop    = ldop;
    bus.mem_addr_lo = addr_lo;
    bus.mem_alu     = alu;
    bus.mem_dmout   = dmout;
    bus.mem_pc4     = pc4;
  endtask

  task automatic offer_md(input logic [4:0] rd, input logic [31:0] data);
    bus.md_valid  = 1'b1;
    bus.md_rd     = rd;
    bus.md_result = data;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] wd);
    exp_q.push_back({rd, wd});
  endtask

  // Scoreboard: every RF write seen mid-cycle must match the next expected one.
  always @(negedge clk) begin
    if (bus.RFWr) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got A3=%0d WD=%h expected no write (t=%0t)",
                 bus.A3, bus.WD, $time);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_write", {27'd0, bus.A3, bus.WD}, {27'd0, sb_e});
      end
    end
  end

  initial begin
    logic [4:0]  rrd;
    logic [31:0] ralu;

    vecs[0]  = '{5'd5,  WDSEL_ALU,  LD_W,  2'd0, 32'h00001234, 32'h80FF7F01, 32'h0, 32'h00001234};
    vecs[1]  = '{5'd6,  WDSEL_LOAD, LD_B,  2'd3, 32'hAAAA5555, 32'h80FF7F01, 32'h0, 32'hFFFFFF80};
    vecs[2]  = '{5'd7,  WDSEL_LOAD, LD_BU, 2'd1, 32'hAAAA5555, 32'h80FF7F01, 32'h0, 32'h0000007F};
    vecs[3]  = '{5'd10, WDSEL_LOAD, LD_H,  2'd2, 32'hAAAA5555, 32'h80FF7F01, 32'h0, 32'hFFFF80FF};
    vecs[4]  = '{5'd11, WDSEL_LOAD, LD_HU, 2'd2, 32'hAAAA5555, 32'h80FF7F01, 32'h0, 32'h000080FF};
    vecs[5]  = '{5'd12, WDSEL_LOAD, LD_W,  2'd1, 32'hAAAA5555, 32'h80FF7F01, 32'h0, 32'h80FF7F01};
    vecs[6]  = '{5'd3,  WDSEL_LOAD, LD_B,  2'd0, 32'hAAAA5555, 32'h80FF7F01, 32'h0, 32'h00000001};
    vecs[7]  = '{5'd4,  WDSEL_LOAD, LD_H,  2'd0, 32'hAAAA5555, 32'h80FF7F01, 32'h0, 32'h00007F01};
    vecs[8]  = '{5'd2,  WDSEL_LOAD, LD_B,  2'd2, 32'hAAAA5555, 32'h80FF7F01, 32'h0, 32'hFFFFFFFF};
    vecs[9]  = '{5'd1,  WDSEL_LOAD, LD_BU, 2'd3, 32'hAAAA5555, 32'h80FF7F01, 32'h0, 32'h00000080};
    vecs[10] = '{5'd31, WDSEL_PC4,  LD_W,  2'd0, 32'hAAAA5555, 32'h80FF7F01, 32'h00400010, 32'h00400010};
    vecs[11] = '{5'd30, WDSEL_LOAD, LD_H,  2'd0, 32'hAAAA5555, 32'h1234ABCD, 32'h0, 32'hFFFFABCD};

    // Reset state
    idle_inputs();
    bus.q_rs = 5'd8;
    bus.q_rt = 5'd9;
    #1;
    chk("rst_rfwr",      bus.RFWr, 0);
    chk("rst_a3",        bus.A3, 0);
    chk("rst_wd",        bus.WD, 0);
    chk("rst_md_ready",  bus.md_ready, 1);
    chk("rst_stall_req", bus.stall_req, 0);
    chk("rst_pend_rs",   bus.pend_rs, 0);
    chk("rst_pend_rt",   bus.pend_rt, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    tick();

    // Table-driven single-cycle writes, back to back
    for (int i = 0; i < 12; i++) begin
      drive_mem(vecs[i].rd, vecs[i].wdsel, vecs[i].ldop, vecs[i].addr_lo,
                vecs[i].alu, vecs[i].dmout, vecs[i].pc4);
      expect_wr(vecs[i].rd, vecs[i].exp_wd);
      tick();
      chk("vec_rfwr", bus.RFWr, 1);
      chk("vec_a3",   bus.A3, vecs[i].rd);
      chk("vec_wd",   bus.WD, vecs[i].exp_wd);
    end
    idle_inputs();
    tick();
    chk("idle_after_table", bus.RFWr, 0);

    // Random ALU writes
    for (int i = 0; i < 8; i++) begin
      rrd  = 5'($urandom_range(1, 31));
      ralu = $urandom;
      drive_mem(rrd, WDSEL_ALU, LD_W, 2'd0, ralu, 32'hDEADBEEF, 32'h0);
      expect_wr(rrd, ralu);
      tick();
      chk("rnd_a3", bus.A3, rrd);
      chk("rnd_wd", bus.WD, ralu);
    end
    idle_inputs();
    tick();

    // md result rd=8 offered while pipeline writes rd=9
    drive_mem(5'd9, WDSEL_ALU, LD_W, 2'd0, 32'h99, 32'h0, 32'h0);
    expect_wr(5'd9, 32'h99);
    expect_wr(5'd8, 32'h88);
    tick();
    bus.mem_valid = 1'b0;
    offer_md(5'd8, 32'h88);
    bus.q_rs = 5'd8;
    #1;
    chk("ord_first_a3",   bus.A3, 9);
    chk("ord_pend_offer", bus.pend_rs, 1);
    tick();
    bus.md_valid = 1'b0;
    #1;
    chk("ord_second_a3",  bus.A3, 8);
    chk("ord_second_wr",  bus.RFWr, 1);
    chk("ord_pend_buf",   bus.pend_rs, 1);
    tick();
    chk("ord_pend_clear", bus.pend_rs, 0);
    chk("ord_idle",       bus.RFWr, 0);

    // Fill the buffer while pipeline writes keep the port busy
    idle_inputs();
    drive_mem(5'd16, WDSEL_ALU, LD_W, 2'd0, 32'hA16, 32'h0, 32'h0);
    offer_md(5'd20, 32'hD20);
    expect_wr(5'd16, 32'hA16);
    expect_wr(5'd20, 32'hD20);
    expect_wr(5'd17, 32'hB17);
    expect_wr(5'd21, 32'hD21);
    tick();
    chk("fill_a_a3",      bus.A3, 16);
    chk("fill_ready_1",   bus.md_ready, 1);
    drive_mem(5'd17, WDSEL_ALU, LD_W, 2'd0, 32'hB17, 32'h0, 32'h0);
    offer_md(5'd21, 32'hD21);
    tick();
    chk("full_ready_0",   bus.md_ready, 0);
    chk("full_stall_req", bus.stall_req, 1);
    chk("full_head_a3",   bus.A3, 20);
    idle_inputs();
    tick();
    chk("drain_pipe_a3",  bus.A3, 17);
    chk("drain_stall_0",  bus.stall_req, 0);
    chk("drain_ready_1",  bus.md_ready, 1);
    tick();
    bus.q_rs = 5'd21;
    #1;
    chk("drain_tail_a3",  bus.A3, 21);
    chk("drain_tail_pend", bus.pend_rs, 1);
    tick();
    chk("drain_idle",     bus.RFWr, 0);
    chk("drain_pend_0",   bus.pend_rs, 0);

    // rd==0 pipeline write and rd==0 buffered result
    idle_inputs();
    drive_mem(5'd0, WDSEL_ALU, LD_W, 2'd0, 32'hDEAD, 32'h0, 32'h0);
    offer_md(5'd0, 32'hBEEF);
    tick();
    chk("rd0_pop_nowr", bus.RFWr, 0);
    idle_inputs();
    bus.wb_stall = 1'b1;
    tick();
    chk("rd0_hold_nowr", bus.RFWr, 0);
    bus.wb_stall = 1'b0;
    offer_md(5'd23, 32'hD23);
    expect_wr(5'd23, 32'hD23);
    tick();
    bus.md_valid = 1'b0;
    #1;
    chk("rd0_popped_next_a3", bus.A3, 23);
    tick();
    chk("rd0_idle", bus.RFWr, 0);

    // wb_stall holds a written entry without repeating its write
    drive_mem(5'd13, WDSEL_ALU, LD_W, 2'd0, 32'h13, 32'h0, 32'h0);
    expect_wr(5'd13, 32'h13);
    tick();
    chk("hold_first_a3", bus.A3, 13);
    bus.mem_valid = 1'b0;
    bus.wb_stall  = 1'b1;
    tick();
    chk("hold_no_repeat_1", bus.RFWr, 0);
    tick();
    chk("hold_no_repeat_2", bus.RFWr, 0);
    bus.wb_stall = 1'b0;
    tick();
    chk("hold_release_bubble", bus.RFWr, 0);

    // Flush overrides stall at capture
    drive_mem(5'd14, WDSEL_ALU, LD_W, 2'd0, 32'h14, 32'h0, 32'h0);
    bus.wb_flush = 1'b1;
    bus.wb_stall = 1'b1;
    tick();
    chk("flush_nowr", bus.RFWr, 0);
    idle_inputs();
    tick();

    // Reset mid-run with one buffered entry
    drive_mem(5'd15, WDSEL_ALU, LD_W, 2'd0, 32'h15, 32'h0, 32'h0);
    offer_md(5'd22, 32'hD22);
    tick();
    idle_inputs();
    bus.q_rs = 5'd22;
    #1;
    chk("mrst_pre_a3",   bus.A3, 15);
    chk("mrst_pre_pend", bus.pend_rs, 1);
    rst = 1'b0;
    #1;
    chk("mrst_rfwr",     bus.RFWr, 0);
    chk("mrst_md_ready", bus.md_ready, 1);
    chk("mrst_pend",     bus.pend_rs, 0);
    chk("mrst_a3",       bus.A3, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_no_stale", bus.RFWr, 0);
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
